integration_event_logger: RTL and testbench

// - Sits directly downstream of system_integration_validator; consumes its three level alerts.
// - Converts rising edges into timestamped event records held in a FIFO.
// - Records drain via a valid/ready pop port; keeps per-source counters and overflow status.
// - Raises an interrupt when the FIFO passes a threshold or an event is lost.

---
 rtl/integration_event_logger.sv | 171 +++++++++++++++++
 tb/tb_integration_event_logger.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/integration_event_logger.sv
// rtl/integration_event_logger.sv - timestamped event FIFO for validator alerts
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   protocol_violation_i       alert level inputs from the validator
//   connectivity_error_i
//   system_health_alert_i
//   evt_valid_o/evt_ready_i    FIFO head pop handshake
//   evt_src_o, evt_ts_o        head record: source mask {health,conn,proto}, timestamp
//   count_o                    FIFO occupancy 0..DEPTH
//   overflow_o, overflow_cnt_o sticky drop flag and saturating drop count
//   proto/conn/health_cnt_o    saturating per-source rising-edge counts
//   irq_o                      registered interrupt: threshold reached or overflow
//   clr_i                      clear counters and overflow status
//   flush_i                    empty the FIFO
module integration_event_logger #(
  parameter int DEPTH      = 8,
  parameter int TS_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int IRQ_THRESH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       protocol_violation_i,
  input  logic                       connectivity_error_i,
  input  logic                       system_health_alert_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [2:0]                 evt_src_o,
  output logic [TS_WIDTH-1:0]        evt_ts_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [CNT_WIDTH-1:0]       overflow_cnt_o,
  output logic [CNT_WIDTH-1:0]       proto_cnt_o,
  output logic [CNT_WIDTH-1:0]       conn_cnt_o,
  output logic [CNT_WIDTH-1:0]       health_cnt_o,
  output logic                       irq_o,
  input  logic                       clr_i,
  input  logic                       flush_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [PTR_W-1:0]     PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        CNT_INC = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        FULL_LV = CW'(DEPTH);
  localparam logic [CW-1:0]        THRESH  = CW'(IRQ_THRESH);
  localparam logic [TS_WIDTH-1:0]  TS_ONE  = {{(TS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] C_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    sat_inc = (en && (v != {CNT_WIDTH{1'b1}})) ? v + C_ONE : v;
  endfunction

  logic [2:0]           in_vec;
  logic [2:0]           prev_q;
  logic [2:0]           edge_v;
  logic [TS_WIDTH-1:0]  ts_q;

  logic [2:0]           src_mem [DEPTH];
  logic [TS_WIDTH-1:0]  ts_mem  [DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]        count_q, count_next;

  logic                 ovf_q, ovf_next;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_next;
  logic [CNT_WIDTH-1:0] proto_cnt_q, conn_cnt_q, health_cnt_q;
  logic                 irq_q;

  logic                 full, not_empty;
  logic                 push_req, push_acc, pop, drop;

  assign in_vec    = {system_health_alert_i, connectivity_error_i, protocol_violation_i};
  assign edge_v    = in_vec & ~prev_q;
  assign full      = (count_q == FULL_LV);
  assign not_empty = (count_q != '0);

  // Flush suppresses both sides of the FIFO; a pop frees the slot a full
  // FIFO needs, so push and pop together never drop.
  assign push_req = (|edge_v) & ~flush_i;
  assign pop      = not_empty & evt_ready_i & ~flush_i;
  assign push_acc = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    count_next = count_q;
    if (flush_i) begin
      count_next = '0;
    end else begin
      case ({push_acc, pop})
        2'b10:   count_next = count_q + CNT_INC;
        2'b01:   count_next = count_q - CNT_INC;
        default: count_next = count_q;
      endcase
    end
  end

  // Clear has priority over an overflow occurring in the same cycle.
  always_comb begin
    ovf_next     = ovf_q;
    ovf_cnt_next = ovf_cnt_q;
    if (clr_i) begin
      ovf_next     = 1'b0;
      ovf_cnt_next = '0;
    end else if (drop) begin
      ovf_next     = 1'b1;
      ovf_cnt_next = sat_inc(ovf_cnt_q, 1'b1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q       <= '0;
      ts_q         <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      ovf_cnt_q    <= '0;
      proto_cnt_q  <= '0;
      conn_cnt_q   <= '0;
      health_cnt_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      prev_q  <= in_vec;
      ts_q    <= ts_q + TS_ONE;
      count_q <= count_next;
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_acc) wptr_q <= wptr_q + PTR_ONE;
        if (pop)      rptr_q <= rptr_q + PTR_ONE;
      end
      ovf_q     <= ovf_next;
      ovf_cnt_q <= ovf_cnt_next;
      if (clr_i) begin
        proto_cnt_q  <= '0;
        conn_cnt_q   <= '0;
        health_cnt_q <= '0;
      end else begin
        proto_cnt_q  <= sat_inc(proto_cnt_q,  edge_v[0]);
        conn_cnt_q   <= sat_inc(conn_cnt_q,   edge_v[1]);
        health_cnt_q <= sat_inc(health_cnt_q, edge_v[2]);
      end
      irq_q <= (count_next >= THRESH) | ovf_next;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      src_mem[wptr_q] <= edge_v;
      ts_mem[wptr_q]  <= ts_q;
    end
  end

  assign evt_valid_o    = not_empty;
  assign evt_src_o      = not_empty ? src_mem[rptr_q] : 3'b000;
  assign evt_ts_o       = not_empty ? ts_mem[rptr_q]  : '0;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign overflow_cnt_o = ovf_cnt_q;
  assign proto_cnt_o    = proto_cnt_q;
  assign conn_cnt_o     = conn_cnt_q;
  assign health_cnt_o   = health_cnt_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_integration_event_logger.sv
// tb/tb_integration_event_logger.sv - randomized model-checked bench for integration_event_logger
module tb_integration_event_logger;

  localparam int DEPTH  = 8;
  localparam int TS_W   = 8;
  localparam int CNT_W  = 4;
  localparam int THRESH = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, p, c, h, ready, clr, flush;
  logic                 evt_valid;
  logic [2:0]           evt_src;
  logic [TS_W-1:0]      evt_ts;
  logic [$clog2(DEPTH):0] count;
  logic                 ovf, irq;
  logic [CNT_W-1:0]     ovf_cnt, p_cnt, c_cnt, h_cnt;

  always #5 clk = ~clk;

  integration_event_logger #(
    .DEPTH(DEPTH), .TS_WIDTH(TS_W), .CNT_WIDTH(CNT_W), .IRQ_THRESH(THRESH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .protocol_violation_i(p), .connectivity_error_i(c), .system_health_alert_i(h),
    .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_src_o(evt_src), .evt_ts_o(evt_ts),
    .count_o(count), .overflow_o(ovf), .overflow_cnt_o(ovf_cnt),
    .proto_cnt_o(p_cnt), .conn_cnt_o(c_cnt), .health_cnt_o(h_cnt),
    .irq_o(irq), .clr_i(clr), .flush_i(flush)
  );

  typedef struct {
    logic [2:0]      src;
    logic [TS_W-1:0] ts;
  } rec_t;

  rec_t        mq[$];
  int unsigned m_ts;
  logic [2:0]  m_prev;
  int          m_cnt[3];
  bit          m_ovf;
  int          m_ovfc;
  bit          m_irq;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts = 0; m_prev = 3'b000;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_ovf = 0; m_ovfc = 0; m_irq = 0;
  endtask

  // Next-state of the observable behaviour, computed from the inputs held
  // across the edge that just occurred.
  task automatic model_edge();
    logic [2:0] in_v, e;
    bit do_pop, drop;
    rec_t r;
    in_v = {h, c, p};
    if (!rst_n) begin
      model_reset();
      return;
    end
    e      = in_v & ~m_prev;
    do_pop = (mq.size() > 0) && ready && !flush;
    drop   = 0;
    if (flush) begin
      mq.delete();
    end else begin
      if (e != 0 && mq.size() == DEPTH && !do_pop) drop = 1;
      if (do_pop) void'(mq.pop_front());
      if (e != 0 && !drop) begin
        r.src = e;
        r.ts  = m_ts[TS_W-1:0];
        mq.push_back(r);
      end
    end
    if (clr) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_ovf = 0; m_ovfc = 0;
    end else begin
      for (int i = 0; i < 3; i++) if (e[i] && m_cnt[i] < MAXC) m_cnt[i]++;
      if (drop) begin
        m_ovf = 1;
        if (m_ovfc < MAXC) m_ovfc++;
      end
    end
    m_irq  = (mq.size() >= THRESH) || m_ovf;
    m_ts   = (m_ts + 1) % (1 << TS_W);
    m_prev = in_v;
  endtask

  task automatic compare_all();
    bit v;
    v = mq.size() > 0;
    chk("evt_valid", evt_valid, v);
    chk("evt_src",   evt_src,   v ? mq[0].src : 3'b000);
    chk("evt_ts",    evt_ts,    v ? mq[0].ts  : '0);
    chk("count",     count,     mq.size());
    chk("overflow",  ovf,       m_ovf);
    chk("ovf_cnt",   ovf_cnt,   m_ovfc);
    chk("proto_cnt", p_cnt,     m_cnt[0]);
    chk("conn_cnt",  c_cnt,     m_cnt[1]);
    chk("health_cnt", h_cnt,    m_cnt[2]);
    chk("irq",       irq,       m_irq);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic idle_inputs();
    p = 0; c = 0; h = 0; ready = 0; clr = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    chk("reset_valid", evt_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_irq", irq, 0);
    chk("reset_pcnt", p_cnt, 0);

    // Single proto event at ts=5 held without ready.
    for (int i = 0; i < 5; i++) step();
    p = 1;
    step();
    chk("s1_valid", evt_valid, 1);
    chk("s1_src", evt_src, 3'b001);
    chk("s1_ts", evt_ts, 5);
    chk("s1_pcnt", p_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s1_hold_ts", evt_ts, 5);
      chk("s1_hold_src", evt_src, 3'b001);
    end
    ready = 1;
    step();
    chk("s1_popped", evt_valid, 0);
    idle_inputs();
    step();

    // Coincident conn+health edge, then a long-held proto level.
    do_reset();
    c = 1; h = 1;
    step();
    chk("s2_src", evt_src, 3'b110);
    chk("s2_count", count, 1);
    p = 1;
    for (int i = 0; i < 10; i++) step();
    chk("s2_held_pcnt", p_cnt, 1);
    chk("s2_count2", count, 2);
    idle_inputs();

    // Fill past DEPTH with separate proto pulses.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      p = 1;
      step();
      chk("s3_irq_fill", irq, (k >= THRESH));
      p = 0;
      step();
    end
    chk("s3_count", count, 8);
    chk("s3_ovf", ovf, 1);
    chk("s3_ovf_cnt", ovf_cnt, 1);
    chk("s3_pcnt", p_cnt, 9);

    // Push and pop together while full.
    p = 1; ready = 1;
    step();
    chk("s4_count", count, 8);
    chk("s4_ovf_cnt", ovf_cnt, 1);
    p = 0; ready = 0;
    step();

    // Flush and clear together with a coincident edge.
    p = 1; flush = 1; clr = 1;
    step();
    chk("s5_count", count, 0);
    chk("s5_valid", evt_valid, 0);
    chk("s5_ovf", ovf, 0);
    chk("s5_ovf_cnt", ovf_cnt, 0);
    chk("s5_pcnt", p_cnt, 0);
    chk("s5_irq", irq, 0);
    idle_inputs();
    step();

    // Reset with entries queued and ready high.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      p = 1; step();
      p = 0; step();
    end
    chk("s6_count5", count, 5);
    ready = 1; c = 1; rst_n = 0;
    step();
    chk("s6_valid", evt_valid, 0);
    chk("s6_count", count, 0);
    chk("s6_pcnt", p_cnt, 0);
    chk("s6_irq", irq, 0);
    rst_n = 1; ready = 0;
    step();
    chk("s6_rel_valid", evt_valid, 1);
    chk("s6_rel_src", evt_src, 3'b010);
    chk("s6_rel_ts", evt_ts, 0);
    idle_inputs();

    // Randomized traffic with phases of slow and fast draining.
    for (int i = 0; i < 6000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 300) % 3 == 0) ? 10 : (((i / 300) % 3 == 1) ? 50 : 90);
      if ($urandom_range(0, 2) == 0) p = ~p;
      if ($urandom_range(0, 3) == 0) c = ~c;
      if ($urandom_range(0, 4) == 0) h = ~h;
      ready = ($urandom_range(0, 99) < rdy_pct);
      flush = ($urandom_range(0, 79) == 0);
      clr   = ($urandom_range(0, 149) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      step();
    end
    rst_n = 1;
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
